// File: rtl/c7bifu_fcl_mo.sv
// Multi-outstanding fetch control: issues incrementing fetch requests, tracks in-flight fetches, squashes on redirect.
// Latency: request/accept zero-latency (addr/count update next cycle); fetch_valid is combinational from data_valid.
// Backpressure: req drops when in-flight count is full, the instruction buffer stalls, or an exception is present.
module c7bifu_fcl_mo #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int PC_W = 32,
  parameter int FETCH_BYTES = 8,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c00_0000,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ifu_icu_req_ic1,
  output logic [PC_W-1:0]  ifu_icu_addr_ic1,
  input  logic             icu_ifu_ack_ic1,
  input  logic             icu_ifu_data_valid_ic2,
  input  logic             exu_ifu_except,
  input  logic [PC_W-1:0]  exu_ifu_except_pc,
  input  logic             ib_ifu_stall,
  output logic             ifu_fetch_valid,
  output logic [CNT_W-1:0] ifu_outstanding,
  output logic             ifu_proto_err
);

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outst_cnt_q, outst_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
  logic             proto_err_q, proto_err_d;

  logic acc;
  logic ret;
  logic [CNT_W-1:0] cnt_after;

  // Request/accept/return decode and next-state for every counter and the fetch address.
  always_comb begin
    ifu_icu_req_ic1 = !reset && (outst_cnt_q < CNT_W'(MAX_OUTSTANDING))
                      && !ib_ifu_stall && !exu_ifu_except;
    acc = ifu_icu_req_ic1 && icu_ifu_ack_ic1;
    // A response with nothing in flight is a protocol violation and must not underflow the count.
    ret = icu_ifu_data_valid_ic2 && (outst_cnt_q != '0);
    cnt_after = outst_cnt_q + CNT_W'(acc) - CNT_W'(ret);

    outst_cnt_d = cnt_after;

    fetch_pc_d = fetch_pc_q;
    if (exu_ifu_except) begin
      fetch_pc_d = exu_ifu_except_pc;
    end else if (acc) begin
      fetch_pc_d = fetch_pc_q + PC_W'(FETCH_BYTES);
    end

    // On redirect everything still in flight (including this cycle's accept) is stale;
    // a later redirect simply overwrites the count.
    squash_cnt_d = squash_cnt_q;
    if (exu_ifu_except) begin
      squash_cnt_d = cnt_after;
    end else if (ret && (squash_cnt_q != '0)) begin
      squash_cnt_d = squash_cnt_q - CNT_W'(1);
    end

    proto_err_d = proto_err_q || (icu_ifu_data_valid_ic2 && (outst_cnt_q == '0));

    ifu_fetch_valid  = ret && (squash_cnt_q == '0) && !exu_ifu_except;
    ifu_icu_addr_ic1 = fetch_pc_q;
    ifu_outstanding  = outst_cnt_q;
    ifu_proto_err    = proto_err_q;
  end

  // State registers with synchronous reset; reset discards all in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      outst_cnt_q  <= '0;
      squash_cnt_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      outst_cnt_q  <= outst_cnt_d;
      squash_cnt_q <= squash_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_c7bifu_fcl_mo.sv
// Scoreboard bench for c7bifu_fcl_mo: a 32-bit default instance and an 8-bit wrapping instance share stimulus.
// Expectations come from an in-flight list model; a negedge monitor pops and compares them.
// Directed test-plan sequences followed by randomized traffic.
module tb_c7bifu_fcl_mo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ack = 1'b0;
  logic        dv = 1'b0;
  logic        exc = 1'b0;
  logic [31:0] epc = '0;
  logic        stall = 1'b0;

  logic        req0, req1;
  logic [31:0] addr0;
  logic [7:0]  addr1;
  logic        fv0, fv1;
  logic [1:0]  cnt0, cnt1;
  logic        perr0, perr1;

  always #5 clk = ~clk;

  c7bifu_fcl_mo dut0 (
    .clk(clk), .reset(reset),
    .ifu_icu_req_ic1(req0), .ifu_icu_addr_ic1(addr0),
    .icu_ifu_ack_ic1(ack), .icu_ifu_data_valid_ic2(dv),
    .exu_ifu_except(exc), .exu_ifu_except_pc(epc),
    .ib_ifu_stall(stall), .ifu_fetch_valid(fv0),
    .ifu_outstanding(cnt0), .ifu_proto_err(perr0)
  );

  c7bifu_fcl_mo #(.PC_W(8), .RESET_PC(8'hF8)) dut1 (
    .clk(clk), .reset(reset),
    .ifu_icu_req_ic1(req1), .ifu_icu_addr_ic1(addr1),
    .icu_ifu_ack_ic1(ack), .icu_ifu_data_valid_ic2(dv),
    .exu_ifu_except(exc), .exu_ifu_except_pc(epc[7:0]),
    .ib_ifu_stall(stall), .ifu_fetch_valid(fv1),
    .ifu_outstanding(cnt1), .ifu_proto_err(perr1)
  );

  typedef struct {
    bit                full;
    logic [1:0]        req;
    logic [1:0][31:0]  addr;
    logic [1:0]        fv;
    logic [1:0][31:0]  cnt;
    logic [1:0]        perr;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: per instance, an ordered list of in-flight fetches, each flagged stale or live.
  int          m_n[2];
  bit          m_stale[2][16];
  logic [31:0] m_pc[2];
  bit          m_perr[2];
  logic [31:0] m_mask[2];
  logic [31:0] m_rst_pc[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
  endtask

  task automatic step(input bit r, input bit a, input bit d, input bit e,
                      input logic [31:0] pc_tgt, input bit s);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; ack = a; dv = d; exc = e; epc = pc_tgt; stall = s;
    x.full = !r;
    for (int i = 0; i < 2; i++) begin
      bit rq, acc, ret;
      rq  = !r && (m_n[i] < 2) && !s && !e;
      acc = rq && a;
      ret = d && (m_n[i] > 0);
      x.req[i]  = rq;
      x.addr[i] = m_pc[i];
      x.fv[i]   = ret && !m_stale[i][0] && !e;
      x.cnt[i]  = m_n[i];
      x.perr[i] = m_perr[i];
      if (r) begin
        m_n[i] = 0; m_pc[i] = m_rst_pc[i]; m_perr[i] = 1'b0;
      end else begin
        if (d && m_n[i] == 0) m_perr[i] = 1'b1;
        if (ret) begin
          for (int k = 0; k < 15; k++) m_stale[i][k] = m_stale[i][k+1];
          m_n[i]--;
        end
        if (acc) begin
          m_stale[i][m_n[i]] = 1'b0;
          m_n[i]++;
        end
        if (e) begin
          for (int k = 0; k < 16; k++) m_stale[i][k] = 1'b1;
          m_pc[i] = pc_tgt & m_mask[i];
        end else if (acc) begin
          m_pc[i] = (m_pc[i] + 32'd8) & m_mask[i];
        end
      end
    end
    sb.push_back(x);
  endtask

  // Monitor: compares every cycle's expected outputs; during reset only req is meaningful.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check("req0", {31'd0, req0}, {31'd0, x.req[0]});
      check("req1", {31'd0, req1}, {31'd0, x.req[1]});
      if (x.full) begin
        check("addr0", addr0, x.addr[0]);
        check("addr1", {24'd0, addr1}, x.addr[1]);
        check("fv0", {31'd0, fv0}, {31'd0, x.fv[0]});
        check("fv1", {31'd0, fv1}, {31'd0, x.fv[1]});
        check("cnt0", {30'd0, cnt0}, x.cnt[0]);
        check("cnt1", {30'd0, cnt1}, x.cnt[1]);
        check("perr0", {31'd0, perr0}, {31'd0, x.perr[0]});
        check("perr1", {31'd0, perr1}, {31'd0, x.perr[1]});
      end
    end
  end

  initial begin
    m_mask[0] = 32'hFFFF_FFFF; m_rst_pc[0] = 32'h1c00_0000;
    m_mask[1] = 32'h0000_00FF; m_rst_pc[1] = 32'h0000_00F8;
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_pc[i] = m_rst_pc[i]; m_perr[i] = 1'b0;
      for (int k = 0; k < 16; k++) m_stale[i][k] = 1'b0;
    end

    // Reset, then idle with no ack: req held, address at reset PC.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0);
    // Single accept (8-bit instance wraps F8 -> 00), then its response.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Fill to depth: third ack ignored; then return with ack high.
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Simultaneous ack and return at one outstanding.
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Reach two outstanding, redirect with ack, squash both, third returns live.
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'h1c00_0100, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Stall for four cycles with nothing outstanding, then release.
    repeat (4) step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    // Response with nothing outstanding: sticky error until reset.
    step(0, 0, 1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 150) == 0, $urandom % 2, ($urandom % 3) == 0,
           ($urandom % 20) == 0, $urandom, ($urandom % 8) == 0);
    end
    step(0, 0, 0, 0, 0, 0);

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 5 && sb.size() > 0; t++) @(posedge clk);
    @(posedge clk);
    check("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
